// File: rtl/iob_eth_axi_responder_if.sv
// AXI4 bus between the Ethernet DMA (master) and its memory responder (slave).
// Carries the AW, W, B, AR and R channels. Only the 32-bit data width is supported.
interface iob_eth_axi_responder_if #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1
);
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [AXI_LEN_W-1:0]    awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [AXI_LEN_W-1:0]    arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/iob_eth_axi_responder.sv
// AXI4 slave serving one INCR burst at a time onto a single-port word RAM; writes 1 beat/cycle,
// reads 2 cycles AR->first beat and 1 beat per 2 cycles; every channel waits on its valid/ready.
module iob_eth_axi_responder #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cke_i,
  iob_eth_axi_responder_if.slave    axi,
  output logic                      mem_en_o,
  output logic [AXI_DATA_W/8-1:0]   mem_we_o,
  output logic [MEM_ADDR_W-1:0]     mem_addr_o,
  output logic [AXI_DATA_W-1:0]     mem_wdata_o,
  input  logic [AXI_DATA_W-1:0]     mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA} state_e;

  state_e                  state_q, state_d;
  logic                    last_wr_q, last_wr_d;
  logic [AXI_ID_W-1:0]     id_q, id_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [AXI_LEN_W-1:0]    len_q, len_d;
  logic [AXI_LEN_W-1:0]    beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    wlast_err_q, wlast_err_d;
  logic                    rd_first_q, rd_first_d;
  logic [AXI_DATA_W-1:0]   rdata_q, rdata_d;

  logic                    is_last;
  logic                    unused_addr_bits;

  assign is_last = (beat_q == len_q);
  assign unused_addr_bits = ^{axi.awaddr[AXI_ADDR_W-1:MEM_ADDR_W+2], axi.awaddr[1:0],
                              axi.araddr[AXI_ADDR_W-1:MEM_ADDR_W+2], axi.araddr[1:0]};

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    err_d       = err_q;
    wlast_err_d = wlast_err_q;
    rd_first_d  = rd_first_q;
    rdata_d     = rdata_q;
    axi.awready = 1'b0;
    axi.arready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = 2'b00;
    axi.rvalid  = 1'b0;
    axi.rid     = '0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    // Outputs are forced quiet while reset is asserted so no beat is accepted mid-abort.
    if (rst_n_i) begin
      unique case (state_q)
        IDLE: begin
          axi.awready = axi.awvalid && (!axi.arvalid || !last_wr_q);
          axi.arready = axi.arvalid && (!axi.awvalid || last_wr_q);
          if (axi.awready) begin
            id_d        = axi.awid;
            addr_d      = axi.awaddr[MEM_ADDR_W+1:2];
            len_d       = axi.awlen;
            beat_d      = '0;
            err_d       = (axi.awburst != 2'b01) || (axi.awsize != 3'd2);
            wlast_err_d = 1'b0;
            state_d     = WR_DATA;
          end else if (axi.arready) begin
            id_d        = axi.arid;
            addr_d      = axi.araddr[MEM_ADDR_W+1:2];
            len_d       = axi.arlen;
            beat_d      = '0;
            err_d       = (axi.arburst != 2'b01) || (axi.arsize != 3'd2);
            wlast_err_d = 1'b0;
            state_d     = RD_ISSUE;
          end
        end
        WR_DATA: begin
          axi.wready = 1'b1;
          if (axi.wvalid) begin
            mem_en_o    = 1'b1;
            mem_we_o    = err_q ? '0 : axi.wstrb;
            mem_addr_o  = addr_q;
            mem_wdata_o = axi.wdata;
            addr_d      = addr_q + 1'b1;
            beat_d      = beat_q + 1'b1;
            if (axi.wlast != is_last) wlast_err_d = 1'b1;
            if (is_last) state_d = WR_RESP;
          end
        end
        WR_RESP: begin
          axi.bvalid = 1'b1;
          axi.bid    = id_q;
          axi.bresp  = (err_q || wlast_err_q) ? 2'b10 : 2'b00;
          if (axi.bready) begin
            last_wr_d = 1'b1;
            state_d   = IDLE;
          end
        end
        RD_ISSUE: begin
          mem_en_o   = 1'b1;
          mem_addr_o = addr_q;
          rd_first_d = 1'b1;
          state_d    = RD_DATA;
        end
        RD_DATA: begin
          // RAM output is only guaranteed on the first data cycle; later stall cycles replay the copy.
          if (rd_first_q) rdata_d = mem_rdata_i;
          rd_first_d = 1'b0;
          axi.rvalid = 1'b1;
          axi.rid    = id_q;
          axi.rdata  = err_q ? '0 : (rd_first_q ? mem_rdata_i : rdata_q);
          axi.rresp  = err_q ? 2'b10 : 2'b00;
          axi.rlast  = is_last;
          if (axi.rready) begin
            if (is_last) begin
              last_wr_d = 1'b0;
              state_d   = IDLE;
            end else begin
              addr_d  = addr_q + 1'b1;
              beat_d  = beat_q + 1'b1;
              state_d = RD_ISSUE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      last_wr_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
      rd_first_q  <= 1'b0;
      rdata_q     <= '0;
    end else if (cke_i) begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      wlast_err_q <= wlast_err_d;
      rd_first_q  <= rd_first_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_iob_eth_axi_responder.sv
// Directed bench for iob_eth_axi_responder: arbitration, burst write/read, errors, wrap, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_iob_eth_axi_responder;
  localparam int MW = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic cke;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [MW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic [31:0]     ram [0:(1<<MW)-1];

  int checks = 0;
  int errors = 0;

  iob_eth_axi_responder_if #(.AXI_ADDR_W(24), .AXI_DATA_W(32), .AXI_LEN_W(8), .AXI_ID_W(1)) axi_if ();

  iob_eth_axi_responder #(
    .AXI_ADDR_W(24), .AXI_DATA_W(32), .AXI_LEN_W(8), .AXI_ID_W(1), .MEM_ADDR_W(MW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .axi(axi_if),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_go(input logic id, input logic [23:0] addr, input logic [7:0] len, input logic [1:0] burst);
    axi_if.awid = id; axi_if.awaddr = addr; axi_if.awlen = len;
    axi_if.awsize = 3'd2; axi_if.awburst = burst; axi_if.awvalid = 1'b1;
    @(negedge clk);
    chk("awready", axi_if.awready, 1);
    chk("aw_arready", axi_if.arready, 0);
    step();
    axi_if.awvalid = 1'b0;
  endtask

  task automatic ar_go(input logic id, input logic [23:0] addr, input logic [7:0] len, input logic [1:0] burst);
    axi_if.arid = id; axi_if.araddr = addr; axi_if.arlen = len;
    axi_if.arsize = 3'd2; axi_if.arburst = burst; axi_if.arvalid = 1'b1;
    @(negedge clk);
    chk("arready", axi_if.arready, 1);
    chk("ar_awready", axi_if.awready, 0);
    step();
    axi_if.arvalid = 1'b0;
  endtask

  task automatic w_beats(input logic [MW-1:0] a0, input int n, input int last_idx,
                         input logic [31:0] d0, input logic [3:0] we_exp);
    logic [MW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = a0 + MW'(i);
      axi_if.wvalid = 1'b1; axi_if.wdata = d0 + 32'(i);
      axi_if.wstrb = 4'hF; axi_if.wlast = (i == last_idx);
      @(negedge clk);
      chk("wready", axi_if.wready, 1);
      chk("w_mem_en", mem_en, 1);
      chk("w_mem_we", mem_we, we_exp);
      chk("w_mem_addr", mem_addr, a);
      chk("w_mem_wdata", mem_wdata, d0 + 32'(i));
      chk("w_arready", axi_if.arready, 0);
      step();
    end
    axi_if.wvalid = 1'b0; axi_if.wlast = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] resp, input logic id);
    @(negedge clk);
    chk("bvalid", axi_if.bvalid, 1);
    chk("bresp", axi_if.bresp, resp);
    chk("bid", axi_if.bid, id);
    chk("b_awready", axi_if.awready, 0);
    step();
  endtask

  task automatic r_beats(input logic [MW-1:0] a0, input int n, input logic [31:0] d0,
                         input bit err, input logic id, input bit tog);
    logic [MW-1:0] a;
    bit hs;
    for (int i = 0; i < n; i++) begin
      a = a0 + MW'(i);
      axi_if.rready = tog ? ~axi_if.rready : 1'b1;
      @(negedge clk);
      chk("ri_mem_en", mem_en, 1);
      chk("ri_mem_we", mem_we, 0);
      chk("ri_mem_addr", mem_addr, a);
      chk("ri_rvalid", axi_if.rvalid, 0);
      chk("ri_awready", axi_if.awready, 0);
      step();
      hs = 1'b0;
      while (!hs) begin
        axi_if.rready = tog ? ~axi_if.rready : 1'b1;
        @(negedge clk);
        chk("rvalid", axi_if.rvalid, 1);
        chk("rdata", axi_if.rdata, err ? 32'h0 : d0 + 32'(i));
        chk("rlast", axi_if.rlast, (i == n - 1));
        chk("rresp", axi_if.rresp, err ? 2'b10 : 2'b00);
        chk("rid", axi_if.rid, id);
        hs = axi_if.rready;
        step();
      end
    end
    axi_if.rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cke = 1'b1;
    axi_if.awid = '0; axi_if.awaddr = '0; axi_if.awlen = '0; axi_if.awsize = '0;
    axi_if.awburst = '0; axi_if.awvalid = 1'b0;
    axi_if.wdata = '0; axi_if.wstrb = '0; axi_if.wlast = 1'b0; axi_if.wvalid = 1'b0;
    axi_if.bready = 1'b1;
    axi_if.arid = '0; axi_if.araddr = '0; axi_if.arlen = '0; axi_if.arsize = '0;
    axi_if.arburst = '0; axi_if.arvalid = 1'b0; axi_if.rready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wready", axi_if.wready, 0);
    chk("rst_bvalid", axi_if.bvalid, 0);
    chk("rst_rvalid", axi_if.rvalid, 0);
    chk("rst_rdata", axi_if.rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    step();
    rst_n = 1'b1;

    // Simultaneous AW and AR after reset: write wins the first conflict.
    axi_if.awid = 1'b1; axi_if.awaddr = 24'h100; axi_if.awlen = 8'd3;
    axi_if.awsize = 3'd2; axi_if.awburst = 2'b01; axi_if.awvalid = 1'b1;
    axi_if.arid = 1'b0; axi_if.araddr = 24'h100; axi_if.arlen = 8'd3;
    axi_if.arsize = 3'd2; axi_if.arburst = 2'b01; axi_if.arvalid = 1'b1;
    @(negedge clk);
    chk("arb_awready", axi_if.awready, 1);
    chk("arb_arready", axi_if.arready, 0);
    step();
    axi_if.awvalid = 1'b0;
    w_beats(12'h040, 4, 3, 32'hA0, 4'hF);
    // New AW pending while B completes; read must win the next conflict.
    axi_if.awid = 1'b0; axi_if.awaddr = 24'h3FFC; axi_if.awlen = 8'd1; axi_if.awvalid = 1'b1;
    b_resp(2'b00, 1'b1);
    @(negedge clk);
    chk("arb2_arready", axi_if.arready, 1);
    chk("arb2_awready", axi_if.awready, 0);
    step();
    axi_if.arvalid = 1'b0;
    r_beats(12'h040, 4, 32'hA0, 1'b0, 1'b0, 1'b0);

    // Pending AW is now served: write at the top word wraps to word 0.
    @(negedge clk);
    chk("wrap_awready", axi_if.awready, 1);
    step();
    axi_if.awvalid = 1'b0;
    w_beats(12'hFFF, 2, 1, 32'hB0, 4'hF);
    b_resp(2'b00, 1'b0);
    ar_go(1'b1, 24'h3FFC, 8'd1, 2'b01);
    r_beats(12'hFFF, 2, 32'hB0, 1'b0, 1'b1, 1'b0);

    // Eight-beat read with rready toggling every cycle.
    aw_go(1'b1, 24'h300, 8'd7, 2'b01);
    w_beats(12'h0C0, 8, 7, 32'hC0, 4'hF);
    b_resp(2'b00, 1'b1);
    ar_go(1'b0, 24'h300, 8'd7, 2'b01);
    r_beats(12'h0C0, 8, 32'hC0, 1'b0, 1'b0, 1'b1);

    // FIXED bursts are consumed but flagged and never touch memory.
    aw_go(1'b0, 24'h180, 8'd1, 2'b00);
    w_beats(12'h060, 2, 1, 32'hD0, 4'h0);
    b_resp(2'b10, 1'b0);
    ar_go(1'b1, 24'h100, 8'd1, 2'b00);
    r_beats(12'h040, 2, 32'h0, 1'b1, 1'b1, 1'b0);

    // Reset during the third of five beats aborts the burst without a response.
    aw_go(1'b1, 24'h400, 8'd4, 2'b01);
    w_beats(12'h100, 2, 4, 32'hE0, 4'hF);
    axi_if.wvalid = 1'b1; axi_if.wdata = 32'hE2; axi_if.wstrb = 4'hF;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; axi_if.wvalid = 1'b0;
    @(negedge clk);
    chk("abort_wready", axi_if.wready, 0);
    chk("abort_bvalid", axi_if.bvalid, 0);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_rvalid", axi_if.rvalid, 0);
    step();
    @(negedge clk);
    chk("abort_bvalid2", axi_if.bvalid, 0);
    step();
    aw_go(1'b0, 24'h200, 8'd0, 2'b01);
    w_beats(12'h080, 1, 0, 32'h55, 4'hF);
    b_resp(2'b00, 1'b0);
    ar_go(1'b1, 24'h200, 8'd0, 2'b01);
    r_beats(12'h080, 1, 32'h55, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
